// File: rtl/ddr4_sched_pkg.sv
// ---------------------------------------------------------------------------
// ddr4_sched_pkg
// Shared definitions for the DDR4 frame-buffer command scheduler:
//   CMD_WR / CMD_RD : command-FIFO instruction codes
//   sched_state_e   : scheduler FSM states
//   burst_stride()  : app-address distance between consecutive bursts
// ---------------------------------------------------------------------------
package ddr4_sched_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_UPDATE
    } sched_state_e;

    // Each 512-bit word spans 8 app addresses.
    function automatic int burst_stride(input int bl);
        return bl * 8;
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// ---------------------------------------------------------------------------
// frame_addr_gen
// Burst index and buffer bookkeeping for one channel of the frame scheduler.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : restart the frame at index 0 in buffer load_buf_i
//   load_buf_i    : buffer selected by load_i
//   adv_i         : one burst issued; step the index (wraps after the last)
//   addr_o        : start address of the current burst
//   last_o        : current burst is the last of the frame
//   buf_o         : active buffer index
// TOGGLE_ON_WRAP selects whether the buffer flips when a frame completes
// (writer) or stays put until the next load (reader).
// ---------------------------------------------------------------------------
module frame_addr_gen
    import ddr4_sched_pkg::*;
#(
    parameter int                ADDR_W         = 29,
    parameter int                BL             = 64,
    parameter int                FRAME_BURSTS   = 2025,
    parameter logic [ADDR_W-1:0] BASE0          = '0,
    parameter logic [ADDR_W-1:0] BASE1          = '0,
    parameter bit                TOGGLE_ON_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              load_buf_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              buf_o
);

    localparam int                IDX_W  = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(burst_stride(BL));
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BURSTS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             buf_q, buf_d;

    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        if (load_i) begin
            idx_d = '0;
            buf_d = load_buf_i;
        end else if (adv_i) begin
            if (last_o) begin
                idx_d = '0;
                if (TOGGLE_ON_WRAP) begin
                    buf_d = ~buf_q;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            buf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            buf_q <= buf_d;
        end
    end

    // Sum truncates to ADDR_W bits, giving the modulo-2^ADDR_W wrap.
    assign addr_o = (buf_q ? BASE1 : BASE0) + ADDR_W'(idx_q) * STRIDE;
    assign last_o = (idx_q == IDX_LAST);
    assign buf_o  = buf_q;

endmodule

// File: rtl/ddr4_frame_sched.sv
// ---------------------------------------------------------------------------
// ddr4_frame_sched
// Round-robin burst-command scheduler for the double-buffered DDR4 frame
// buffer (p1_clk domain). The writer fills one buffer while the reader scans
// the most recently completed one.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_enable           : level, permits write commands
//   p2_wr_count         : write data FIFO occupancy in 512-bit words
//   rd_start            : pulse, begin reading the last completed frame
//   p1_rd_en            : one read-FIFO word popped this cycle
//   cmd_full            : command FIFO full
//   cmd_en/intr/bl/addr : registered command to the command FIFO
//   wr_frame_done       : pulse with the last write burst of a frame
//   rd_frame_done       : pulse with the last read burst of a frame
//   wr_buf, rd_buf      : active buffer per channel
// ---------------------------------------------------------------------------
module ddr4_frame_sched
    import ddr4_sched_pkg::*;
#(
    parameter int                ADDR_W       = 29,
    parameter int                BL           = 64,
    parameter int                FRAME_BURSTS = 2025,
    parameter logic [ADDR_W-1:0] BASE0        = 29'h000_0000,
    parameter logic [ADDR_W-1:0] BASE1        = 29'h100_0000,
    parameter int                RD_DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_enable,
    input  logic [6:0]        p2_wr_count,
    input  logic              rd_start,
    input  logic              p1_rd_en,
    input  logic              cmd_full,
    output logic              cmd_en,
    output logic [2:0]        cmd_intr,
    output logic [7:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wr_frame_done,
    output logic              rd_frame_done,
    output logic              wr_buf,
    output logic              rd_buf
);

    localparam logic [7:0] BL8    = 8'(BL);
    localparam logic [7:0] DEPTH8 = 8'(RD_DEPTH);

    sched_state_e      state_q;
    logic              last_wr_q;
    logic              rd_active_q;
    logic              frame_valid_q;
    logic [6:0]        rd_credit_q, rd_credit_d;
    logic [7:0]        credit_inc, credit_dec;

    logic              wr_elig, rd_elig;
    logic              wr_issue, rd_issue, rd_load;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_last, rd_last;

    assign wr_elig  = wr_enable && ({1'b0, p2_wr_count} >= BL8);
    assign rd_elig  = rd_active_q && ({1'b0, rd_credit_q} >= BL8);
    assign wr_issue = (state_q == ST_WR_CMD) && !cmd_full;
    assign rd_issue = (state_q == ST_RD_CMD) && !cmd_full;
    // A new read frame is accepted only when idle and a frame exists.
    assign rd_load  = rd_start && !rd_active_q && frame_valid_q;

    // Credit = free read-FIFO slots. Pops return one, a read claims BL;
    // the floor and ceiling guard against counting past the FIFO's bounds.
    always_comb begin
        credit_inc = {1'b0, rd_credit_q} + {7'd0, p1_rd_en};
        credit_dec = credit_inc;
        if (rd_issue) begin
            credit_dec = (credit_inc >= BL8) ? (credit_inc - BL8) : 8'd0;
        end
        rd_credit_d = (credit_dec > DEPTH8) ? DEPTH8[6:0] : credit_dec[6:0];
    end

    frame_addr_gen #(
        .ADDR_W(ADDR_W), .BL(BL), .FRAME_BURSTS(FRAME_BURSTS),
        .BASE0(BASE0), .BASE1(BASE1), .TOGGLE_ON_WRAP(1'b1)
    ) u_wr_gen (
        .clk(clk), .rst_n(rst_n),
        .load_i(1'b0), .load_buf_i(1'b0), .adv_i(wr_issue),
        .addr_o(wr_addr), .last_o(wr_last), .buf_o(wr_buf)
    );

    // The reader latches the completed buffer at rd_start, so later
    // writer toggles leave it untouched.
    frame_addr_gen #(
        .ADDR_W(ADDR_W), .BL(BL), .FRAME_BURSTS(FRAME_BURSTS),
        .BASE0(BASE0), .BASE1(BASE1), .TOGGLE_ON_WRAP(1'b0)
    ) u_rd_gen (
        .clk(clk), .rst_n(rst_n),
        .load_i(rd_load), .load_buf_i(~wr_buf), .adv_i(rd_issue),
        .addr_o(rd_addr), .last_o(rd_last), .buf_o(rd_buf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_en        <= 1'b0;
            cmd_intr      <= 3'b000;
            cmd_bl        <= 8'd0;
            cmd_addr      <= '0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
            last_wr_q     <= 1'b0;
            rd_active_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            rd_credit_q   <= DEPTH8[6:0];
        end else begin
            cmd_en        <= 1'b0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
            rd_credit_q   <= rd_credit_d;
            if (rd_load) begin
                rd_active_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: state_q <= ST_ARB;
                ST_ARB: begin
                    // On a tie, grant the channel that did not win last time.
                    if (wr_elig && (!rd_elig || !last_wr_q)) begin
                        state_q   <= ST_WR_CMD;
                        last_wr_q <= 1'b1;
                    end else if (rd_elig) begin
                        state_q   <= ST_RD_CMD;
                        last_wr_q <= 1'b0;
                    end
                end
                ST_WR_CMD: begin
                    if (!cmd_full) begin
                        cmd_en        <= 1'b1;
                        cmd_intr      <= CMD_WR;
                        cmd_bl        <= BL8;
                        cmd_addr      <= wr_addr;
                        wr_frame_done <= wr_last;
                        if (wr_last) begin
                            frame_valid_q <= 1'b1;
                        end
                        state_q <= ST_UPDATE;
                    end
                end
                ST_RD_CMD: begin
                    if (!cmd_full) begin
                        cmd_en        <= 1'b1;
                        cmd_intr      <= CMD_RD;
                        cmd_bl        <= BL8;
                        cmd_addr      <= rd_addr;
                        rd_frame_done <= rd_last;
                        if (rd_last) begin
                            rd_active_q <= 1'b0;
                        end
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: state_q <= ST_ARB;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_frame_sched.sv
module tb_ddr4_frame_sched;

    localparam int          ADDR_W = 29;
    localparam int          BLK    = 64;
    localparam int          FB     = 4;
    localparam int          DEPTH  = 64;
    localparam logic [28:0] B0     = 29'h000_0000;
    localparam logic [28:0] B1     = 29'h100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_enable = 1'b0;
    logic [6:0]  p2_wr_count = 7'd0;
    logic        rd_start = 1'b0;
    logic        p1_rd_en = 1'b0;
    logic        cmd_full = 1'b0;
    logic        cmd_en;
    logic [2:0]  cmd_intr;
    logic [7:0]  cmd_bl;
    logic [28:0] cmd_addr;
    logic        wr_frame_done, rd_frame_done, wr_buf, rd_buf;

    int total = 0;
    int bad   = 0;

    // Reference model: frame/burst counters and credit, advanced per edge.
    int          m_wr_idx, m_rd_idx, m_credit;
    bit          m_wr_buf, m_rd_buf, m_fv, m_rd_active;
    int          cyc, last_en, n_wr, n_rd;
    logic [28:0] last_addr;
    int          q_intr[$];
    int          en_cyc[$];

    always #5 clk = ~clk;

    ddr4_frame_sched #(
        .ADDR_W(ADDR_W), .BL(BLK), .FRAME_BURSTS(FB),
        .BASE0(B0), .BASE1(B1), .RD_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_enable(wr_enable), .p2_wr_count(p2_wr_count),
        .rd_start(rd_start), .p1_rd_en(p1_rd_en), .cmd_full(cmd_full),
        .cmd_en(cmd_en), .cmd_intr(cmd_intr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
        .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
        .wr_buf(wr_buf), .rd_buf(rd_buf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] exp_addr(input bit b, input int idx);
        return (b ? B1 : B0) + 29'(idx * BLK * 8);
    endfunction

    function automatic int q_at(input int i);
        if (i < q_intr.size()) return q_intr[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_wr_idx = 0; m_rd_idx = 0; m_credit = DEPTH;
        m_wr_buf = 0; m_rd_buf = 0; m_fv = 0; m_rd_active = 0;
        last_en = -100;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_cmd_intr", cmd_intr, 0);
        chk("rst_cmd_bl", cmd_bl, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_wr_frame_done", wr_frame_done, 0);
        chk("rst_rd_frame_done", rd_frame_done, 0);
        chk("rst_wr_buf", wr_buf, 0);
        chk("rst_rd_buf", rd_buf, 0);
        chk("rst_rd_credit", dut.rd_credit_q, DEPTH);
    endtask

    // Compare the outputs produced by the edge just passed, then advance the
    // model using the inputs that were applied at that edge.
    task automatic observe();
        bit wr_iss, rd_iss, rd_go;
        int c;
        cyc++;
        wr_iss = cmd_en && (cmd_intr == 3'b000);
        rd_iss = cmd_en && (cmd_intr == 3'b001);
        rd_go  = rd_start && !m_rd_active && m_fv;
        if (cmd_en) begin
            q_intr.push_back(int'(cmd_intr));
            en_cyc.push_back(cyc);
            last_addr = cmd_addr;
            chk("cmd_bl", cmd_bl, BLK);
            chk("cmd_spacing", (cyc - last_en) >= 3, 1);
            last_en = cyc;
            if (wr_iss) begin
                n_wr++;
                chk("wr_addr", cmd_addr, exp_addr(m_wr_buf, m_wr_idx));
                chk("wr_frame_done", wr_frame_done, m_wr_idx == FB - 1);
            end else if (rd_iss) begin
                n_rd++;
                chk("rd_needs_active", m_rd_active, 1);
                chk("rd_needs_credit", m_credit >= BLK, 1);
                chk("rd_addr", cmd_addr, exp_addr(m_rd_buf, m_rd_idx));
                chk("rd_frame_done", rd_frame_done, m_rd_idx == FB - 1);
            end else begin
                chk("cmd_intr", cmd_intr, 0);
            end
        end
        chk("wfd_only_with_wr", wr_frame_done && !wr_iss, 0);
        chk("rfd_only_with_rd", rd_frame_done && !rd_iss, 0);

        c = m_credit + (p1_rd_en ? 1 : 0) - (rd_iss ? BLK : 0);
        if (c > DEPTH) c = DEPTH;
        if (c < 0) c = 0;
        m_credit = c;
        if (rd_go) m_rd_buf = ~m_wr_buf;
        if (wr_iss) begin
            if (m_wr_idx == FB - 1) begin
                m_wr_idx = 0; m_wr_buf = ~m_wr_buf; m_fv = 1;
            end else begin
                m_wr_idx++;
            end
        end
        if (rd_iss) begin
            if (m_rd_idx == FB - 1) begin
                m_rd_idx = 0; m_rd_active = 0;
            end else begin
                m_rd_idx++;
            end
        end
        if (rd_go) begin
            m_rd_idx = 0; m_rd_active = 1;
        end
        chk("wr_buf", wr_buf, m_wr_buf);
        chk("rd_buf", rd_buf, m_rd_buf);
        chk("rd_credit", dut.rd_credit_q, m_credit);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic wait_cmds(input int n, input int budget, input string tag);
        int k = 0;
        while (q_intr.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, q_intr.size(), n);
    endtask

    initial begin
        int k;
        int n0;
        cyc = 0; n_wr = 0; n_rd = 0; last_addr = '0;
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // rd_start before any complete frame is ignored
        rd_start = 1'b1; step(); rd_start = 1'b0;
        repeat (6) step();
        chk("early_rd_start_ignored", q_intr.size(), 0);

        // Write-only stream: one command per 3 cycles, frame wraps after FB
        wr_enable = 1'b1; p2_wr_count = 7'd64;
        wait_cmds(4, 40, "wr_four_cmds");
        wr_enable = 1'b0;
        for (int i = 1; i < en_cyc.size() && i < 4; i++)
            chk("wr_cmd_period", en_cyc[i] - en_cyc[i-1], 3);
        for (int i = 0; i < 4; i++)
            chk("wr_intr_seq", q_at(i), 0);
        chk("wr_buf_after_frame", wr_buf, 1);

        // Backpressure: grant held through cmd_full, then issued once
        repeat (4) step();
        cmd_full = 1'b1; wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
        repeat (10) step();
        chk("bp_no_cmd_while_full", q_intr.size(), 4);
        cmd_full = 1'b0;
        repeat (6) step();
        chk("bp_single_cmd", q_intr.size(), 5);
        chk("bp_fifth_addr", last_addr, 29'h100_0000);

        // Read credit: one read, stall, refill, next read
        rd_start = 1'b1; step(); rd_start = 1'b0;
        wait_cmds(6, 10, "rd_first_cmd");
        repeat (20) step();
        chk("rd_stall_count", n_rd, 1);
        chk("rd_first_addr", last_addr, 29'h0);
        rd_start = 1'b1; step(); rd_start = 1'b0;
        repeat (3) step();
        p1_rd_en = 1'b1;
        repeat (64) step();
        p1_rd_en = 1'b0;
        wait_cmds(7, 10, "rd_second_cmd");
        chk("rd_second_count", n_rd, 2);
        chk("rd_second_addr", last_addr, 29'h200);

        // Round-robin: both become eligible together after a read grant
        k = 0;
        p1_rd_en = 1'b1;
        while (m_credit < DEPTH && k < 100) begin
            step();
            k++;
        end
        wr_enable = 1'b1;
        wait_cmds(9, 20, "rr_pair");
        chk("rr_write_first", q_at(7), 0);
        chk("rr_then_read", q_at(8), 1);
        k = 0;
        while (n_rd < 4 && k < 200) begin
            step();
            k++;
        end
        chk("rr_read_not_starved", n_rd, 4);
        wr_enable = 1'b0; p1_rd_en = 1'b0;
        repeat (4) step();

        // Reset in the middle of an active read frame
        rd_start = 1'b1; step(); rd_start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n0 = q_intr.size();
        rd_start = 1'b1; step(); rd_start = 1'b0;
        repeat (6) step();
        chk("post_reset_rd_start_ignored", q_intr.size(), n0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            wr_enable   = ($urandom % 4) != 0;
            p2_wr_count = 7'($urandom_range(0, 127));
            cmd_full    = ($urandom % 4) == 0;
            p1_rd_en    = $urandom % 2;
            rd_start    = ($urandom % 16) == 0;
            step();
        end
        wr_enable = 1'b0; cmd_full = 1'b0; p1_rd_en = 1'b0; rd_start = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
